// File: rtl/regwr_pkg.sv
// regwr_pkg: shared types and widths for the register-file write arbiter.
//   grant_src_e : encoding of the grant_src output (none / ALU / MC / UART)
//   rr_side_e   : which of MC / UART wins the next MC-vs-UART collision
package regwr_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MC   = 2'd2,
    SRC_UART = 2'd3
  } grant_src_e;

  typedef enum logic {
    RR_MC   = 1'b0,
    RR_UART = 1'b1
  } rr_side_e;

endpackage

// File: rtl/regwr_scoreboard.sv
// regwr_scoreboard: busy bit per architectural register, set when a
// multicycle op is issued to it and cleared when its result is written back.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   issue_en, issue_rd  MC op issued this cycle and its destination
//   clr_en, clr_rd      MC result accepted this cycle and its destination
//   rs, rt              issue-stage source registers
//   hazard              busy[rs] | busy[rt] | (issue_en & busy[issue_rd])
module regwr_scoreboard
  import regwr_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  hazard
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    hazard = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      // Clear first, then set, so a same-cycle issue to a retiring register
      // leaves it busy for the new op.
      if (clr_en && clr_rd == REG_ADDR_W'(i)) busy_d[i] = 1'b0;
      if (issue_en && issue_rd == REG_ADDR_W'(i)) busy_d[i] = 1'b1;
      if (busy_q[i] && (rs == REG_ADDR_W'(i) || rt == REG_ADDR_W'(i) ||
                        (issue_en && issue_rd == REG_ADDR_W'(i))))
        hazard = 1'b1;
    end
    busy_d[0] = 1'b0;  // r0 is hardwired zero and never waits on anything
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single integer register-file write port.
// ALU writeback always wins; MC and UART share the remaining cycles
// round-robin. Write-port outputs are registered (RF write lands one cycle
// after acceptance). A starvation counter throttles the ALU via alu_stall
// when MC/UART have been denied STARVE_LIMIT consecutive cycles.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   alu_we/alu_rw/alu_data             ALU writeback (no backpressure)
//   mc_issue/mc_issue_rd               MC op issue (marks rd busy)
//   mc_valid/mc_ready/mc_rw/mc_data    MC result handshake
//   uart_valid/uart_ready/uart_rw/...  UART loader handshake
//   rs, rt, hazard                     issue-stage busy check
//   alu_stall                          ALU must hold writeback next cycle
//   rf_we/rf_rw/rf_wdata/grant_src     registered write port and its source
// Optional feature (macro REGWR_BYPASS_EN): byp_hit1, byp_hit2, byp_data let
// the read mux forward the write that is landing this cycle.
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter int REG_NUM      = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_we,
  input  logic [REG_ADDR_W-1:0] alu_rw,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_issue_rd,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_rw,
  input  logic [DATA_W-1:0]     mc_data,
  input  logic                  uart_valid,
  output logic                  uart_ready,
  input  logic [REG_ADDR_W-1:0] uart_rw,
  input  logic [DATA_W-1:0]     uart_data,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  hazard,
  output logic                  alu_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [1:0]            grant_src
`ifdef REGWR_BYPASS_EN
  ,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [DATA_W-1:0]     byp_data
`endif
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                  mc_grant;
  logic                  uart_grant;
  rr_side_e              rr_q, rr_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  alu_stall_q, alu_stall_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rw_q, rf_rw_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  grant_src_e            grant_src_q, grant_src_d;

  // MC/UART arbitration. Readies are held low during reset so that no
  // requester sees an acceptance that the reset is about to discard.
  always_comb begin
    mc_grant   = 1'b0;
    uart_grant = 1'b0;
    rr_d       = rr_q;
    if (!reset && !alu_we) begin
      if (mc_valid && uart_valid) begin
        // Pointer only moves on a real collision.
        if (rr_q == RR_MC) begin
          mc_grant = 1'b1;
          rr_d     = RR_UART;
        end else begin
          uart_grant = 1'b1;
          rr_d       = RR_MC;
        end
      end else begin
        mc_grant   = mc_valid;
        uart_grant = uart_valid;
      end
    end
  end

  assign mc_ready   = mc_grant;
  assign uart_ready = uart_grant;

  // Next write-port contents.
  always_comb begin
    grant_src_d = SRC_NONE;
    rf_rw_d     = '0;
    rf_wdata_d  = '0;
    if (alu_we) begin
      grant_src_d = SRC_ALU;
      rf_rw_d     = alu_rw;
      rf_wdata_d  = alu_data;
    end else if (mc_grant) begin
      grant_src_d = SRC_MC;
      rf_rw_d     = mc_rw;
      rf_wdata_d  = mc_data;
    end else if (uart_grant) begin
      grant_src_d = SRC_UART;
      rf_rw_d     = uart_rw;
      rf_wdata_d  = uart_data;
    end
    // Writes to r0 complete the handshake but never reach the array.
    rf_we_d = (grant_src_d != SRC_NONE) && (rf_rw_d != '0);
  end

  // Starvation tracking; alu_stall mirrors "counter at limit" once registered.
  always_comb begin
    starve_d = starve_q;
    if (mc_grant || uart_grant)
      starve_d = '0;
    else if ((mc_valid || uart_valid) && alu_we && starve_q != LIMIT)
      starve_d = starve_q + 1'b1;
    alu_stall_d = (starve_d == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= RR_MC;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_rw_q     <= '0;
      rf_wdata_q  <= '0;
      grant_src_q <= SRC_NONE;
    end else begin
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      rf_we_q     <= rf_we_d;
      rf_rw_q     <= rf_rw_d;
      rf_wdata_q  <= rf_wdata_d;
      grant_src_q <= grant_src_d;
    end
  end

  assign alu_stall = alu_stall_q;
  assign rf_we     = rf_we_q;
  assign rf_rw     = rf_rw_q;
  assign rf_wdata  = rf_wdata_q;
  assign grant_src = grant_src_q;

  regwr_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .issue_en (mc_issue),
    .issue_rd (mc_issue_rd),
    .clr_en   (mc_grant),
    .clr_rd   (mc_rw),
    .rs       (rs),
    .rt       (rt),
    .hazard   (hazard)
  );

`ifdef REGWR_BYPASS_EN
  assign byp_hit1 = rf_we_q && (rf_rw_q == rs) && (rf_rw_q != '0);
  assign byp_hit2 = rf_we_q && (rf_rw_q == rt) && (rf_rw_q != '0);
  assign byp_data = rf_wdata_q;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the integer register file.
- Arbitrates three writers: ALU writeback (fixed top priority, no backpressure), the multicycle unit (MC: mul/div/FPU, valid/ready) and the UART loader (valid/ready).
- Tracks registers with MC results outstanding in a busy scoreboard and raises a hazard to the issue stage.
- Sits between the writeback stage, the MC unit, the UART loader and the register file write port.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero.
- STARVE_LIMIT, 8, consecutive denied cycles for MC/UART before the ALU is throttled; range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- alu_we  in  1  ALU writeback valid this cycle
- alu_rw  in  5  ALU destination register
- alu_data  in  32  ALU write data
- mc_issue  in  1  MC op issued this cycle
- mc_issue_rd  in  5  destination register of the issued MC op
- mc_valid  in  1  MC result valid
- mc_ready  out  1  MC result accepted this cycle
- mc_rw  in  5  MC destination register
- mc_data  in  32  MC result data
- uart_valid  in  1  UART write valid
- uart_ready  out  1  UART write accepted this cycle
- uart_rw  in  5  UART destination register
- uart_data  in  32  UART write data
- rs  in  5  issue-stage source register 1
- rt  in  5  issue-stage source register 2
- hazard  out  1  issue must stall: busy[rs], busy[rt] or busy[mc_issue_rd]
- alu_stall  out  1  pipeline must hold ALU writeback next cycle
- rf_we  out  1  register file write enable
- rf_rw  out  5  register file write address
- rf_wdata  out  32  register file write data
- grant_src  out  2  source of the current write: 0 none, 1 ALU, 2 MC, 3 UART

Behaviour:
- Reset values: rf_we=0, rf_rw=0, rf_wdata=0, grant_src=0, alu_stall=0, busy all 0, starve counter 0, round-robin pointer = MC.
- Reset mid-handshake drops any in-flight grant.
- Arbitration is combinational; the write-port outputs are registered, so the register file write happens 1 cycle after acceptance.
- If alu_we=1, the ALU wins; mc_ready=0 and uart_ready=0.
- Otherwise MC and UART are arbitrated round-robin:
  - If only one is valid, it wins.
  - If both are valid, the pointer side wins and the pointer flips to the other side.
- At most one ready is asserted per cycle. A transfer occurs on valid&ready.
- The ready outputs depend on valid inputs in the same cycle; a requester holds valid, rw and data until it is accepted.
- A write with rw=0 completes its handshake but registers rf_we=0 and grant_src equal to the winner.
- Starvation:
  - The counter increments each cycle (mc_valid|uart_valid)&alu_we, saturating at STARVE_LIMIT.
  - It clears on any MC/UART acceptance.
  - alu_stall is registered; it is 1 while the counter equals STARVE_LIMIT.
  - While alu_stall=1 the pipeline guarantees alu_we=0 (bench asserts this).
- Scoreboard:
  - An MC acceptance with rw≠0 clears busy[rw].
  - mc_issue with mc_issue_rd≠0 sets busy[mc_issue_rd].
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is never set.
- hazard is combinational from busy, rs, rt and mc_issue_rd (mc_issue_rd counts only when mc_issue=1).
- The UART and ALU never touch the scoreboard.

Optional Feature:
- Macro: REGWR_BYPASS_EN.
- With the macro defined, two extra outputs are added:
  - byp_hit1 and byp_hit2 (1 bit each): asserted when rf_we=1 and rf_rw equals rs / rt respectively (rf_rw≠0).
  - byp_data (32 bits) = rf_wdata.
  - The read mux uses these to cover the write-then-read cycle.
- Without the macro, these ports are absent and readers see the write one cycle later.

Decomposition:
- Package regwr_pkg:
  - typedef enum of the grant_src encoding (SRC_NONE, SRC_ALU, SRC_MC, SRC_UART).
  - REG_ADDR_W=5, DATA_W=32.
- Natural sub-module: regwr_scoreboard, holding the busy vector with its set/clear/hazard logic.
- Arbitration and starvation logic stay in the top module.

Test Plan:
1. Reset, then alu_we=1 with rw=5 and data 0xDEADBEEF, while MC is valid with rw=6 -> mc_ready=0; next cycle rf_we=1, rf_rw=5, grant_src=1. Then drop alu_we -> MC accepted, next cycle rf_rw=6.
2. MC and UART both valid continuously, no ALU -> grants alternate MC, UART, MC, UART, with exactly one ready per cycle.
3. alu_we held at 1 while uart_valid=1, STARVE_LIMIT=8 -> alu_stall=1 after the 8th denied cycle. Then alu_we=0 -> UART accepted, counter clears, alu_stall returns to 0 the next cycle.
4. mc_issue with rd=7, then rs=7 -> hazard=1. MC write of rw=7 accepted -> hazard=0 next cycle. Same-cycle clear of 7 and new issue to 7 -> busy[7] stays 1.
5. UART write with rw=0 -> uart_ready=1; next cycle rf_we=0, grant_src=3. mc_issue with rd=0 -> hazard never asserted.
6. Assert reset while MC is valid and busy[3]=1 -> next cycle all outputs and busy are 0. With REGWR_BYPASS_EN defined, write rw=4 with rs=4 -> byp_hit1=1 and byp_data equals the written value.
